phase_meas_scheduler: RTL and testbench
=======================================

# phase_meas_scheduler

Time-multiplexes one phase-difference counter across all oscillator neurons of the ONN. On `start` it measures each neuron in turn against the reference oscillator, counting clock cycles from a reference rising edge to the selected neuron's next rising edge. It emits one result per neuron, then signals completion. It sits between the neuron array outputs and the weight/readout logic that consumes per-neuron phases.

## Interface
- `N_NEURONS`, 8: number of neurons measured per sweep (≥2).
- `CNT_W`, 4: phase counter width. Saturation value is `MAX = 2^CNT_W-1`.
- `clk`  in  1: single clock. All inputs are synchronous to it.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: begin a sweep. Sampled only in IDLE.
- `abort`  in  1: end the sweep at the next edge. No further results are emitted.
- `ref_osc`  in  1: reference oscillator output.
- `neuron_osc`  in  N_NEURONS: neuron oscillator outputs.
- `busy`  out  1: high from the cycle after `start` is accepted until the cycle `done` pulses.
- `done`  out  1: one-cycle pulse after the last result, or after an abort.
- `result_valid`  out  1: one-cycle pulse per measured neuron.
- `result_idx`  out  $clog2(N_NEURONS): neuron index of the current result.
- `result_phase`  out  CNT_W: measured phase in clock cycles.
- `result_sat`  out  1: the measurement saturated at MAX without a neuron edge.

## Operation
- Edge detection:
  - `ref_osc` and every `neuron_osc` bit are registered once (`*_q`).
  - A rising edge is `x & ~x_q`.
  - The `*_q` registers reset to 0, so an input already high at reset counts as a rise on the first cycle.
- FSM states: IDLE, ARM, COUNT, EMIT, NEXT.
  - IDLE: `start`=1 → ARM with `sel`=0.
  - ARM: wait for a `ref_osc` rise.
    - If the `neuron_osc[sel]` rise occurs in the same cycle: `cnt`=0 → EMIT.
    - Otherwise: `cnt`=1 → COUNT.
    - With no `ref_osc` rise, stay in ARM indefinitely. `abort` is the only exit.
  - COUNT, each cycle:
    - `neuron_osc[sel]` rise → EMIT with `cnt` unchanged and `sat`=0.
    - Else if `cnt`==MAX → EMIT with `sat`=1.
    - Else `cnt`++.
    - A second `ref_osc` rise during COUNT is ignored.
  - EMIT: drive `result_valid`=1, `result_idx`=`sel`, `result_phase`=`cnt`, `result_sat`=`sat` for exactly one cycle.
    - If `sel`==N_NEURONS-1 → NEXT.
    - Otherwise `sel`++ → ARM.
  - NEXT: drive `done`=1 for one cycle, `busy`=0 → IDLE.
- Abort:
  - `abort` in ARM or COUNT → NEXT. No EMIT for the in-flight neuron.
  - `abort` in EMIT: the result is still emitted, then → NEXT.
  - `abort` in IDLE is ignored.
- `start` outside IDLE is ignored. No queuing.
- `cnt` never wraps. Saturation is the only overflow behaviour.
- Reset:
  - `rst` at any time → IDLE.
  - Clears `sel`, `cnt`, `sat`, all `*_q` registers, and all outputs in the same edge.
  - A mid-sweep reset emits no `done`.

## Timing
- Reset values: `busy`, `done`, `result_valid`, `result_sat`, `result_idx` and `result_phase` are all 0.
- `result_idx` and `result_phase` hold their last value between pulses.
- All outputs are registered.
- `start` accepted at edge t → `busy`=1 from t+1. ARM is active from t+1.
- Phase definition: let the `ref_osc` rise be seen in ARM at cycle r, and the `neuron_osc[sel]` rise at cycle r+k (k ≥ 1, before saturation). Then `result_phase`=k and `result_valid` is high in cycle r+k+1.
- Saturation: `result_valid` is high in cycle r+MAX+1, with `result_phase`=MAX and `result_sat`=1.
- Neuron gap: there is one idle cycle (EMIT) between neurons before the next ARM.
- `done` occurs in the cycle after the last `result_valid`.
- Minimum sweep length: 2·N_NEURONS+2 cycles after `start` (all phases 0, `ref_osc` rising every cycle of ARM).

## Structure
- Shared package `onn_pkg`: `CNT_W` default, the FSM state encoding, and `N_NEURONS` default, so the readout and weight-update blocks agree.
- Sub-module `rise_edge_det`:
  - Parameterised width, `clk`/`rst`, outputs registered `q` and `rise`.
  - Instantiated once for `ref_osc` and once for the `neuron_osc` vector.
- Counter and `sel` mux live in the top module.

## Test plan
- `start`; `ref_osc` rises at r; `neuron_osc[0]` rises at r+5 → `result_valid` at r+6, `result_idx`=0, `result_phase`=5, `result_sat`=0.
- `ref_osc` and `neuron_osc[k]` rise in the same cycle → `result_phase`=0, `result_sat`=0.
- `neuron_osc[2]` held low with `CNT_W`=4 → `result_phase`=15, `result_sat`=1 at r+16. The sweep continues with `result_idx`=3.
- Full sweep with N_NEURONS=8 and phases 1..8 → 8 `result_valid` pulses with idx 0..7 and matching phases. `done` is high one cycle after the 8th pulse. `busy` falls with `done`.
- `abort` during COUNT of idx 3 → no result for idx 3; `done` pulses next cycle. A `start` during the sweep produces no effect.
- `rst` asserted in COUNT → next cycle all outputs are 0 and the state is IDLE, with no `done`. A new `start` then measures from idx 0.

Source files
------------

// File: rtl/onn_pkg.sv
// -----------------------------------------------------------------------------
// onn_pkg
// Shared definitions for the ONN phase-measurement path, so the scheduler,
// the readout and the weight-update logic agree on defaults and encodings.
//   N_NEURONS_DEF : default number of neurons measured per sweep
//   CNT_W_DEF     : default phase counter width
//   meas_state_t  : scheduler FSM state encoding
//   idx_width()   : width of a neuron index (never narrower than 1 bit)
// -----------------------------------------------------------------------------
package onn_pkg;

    localparam int N_NEURONS_DEF = 8;
    localparam int CNT_W_DEF     = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ARM   = 3'd1,
        ST_COUNT = 3'd2,
        ST_EMIT  = 3'd3,
        ST_NEXT  = 3'd4
    } meas_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_meas_scheduler_if.sv
// -----------------------------------------------------------------------------
// phase_meas_scheduler_if
// Control, oscillator and result signals of the phase-measurement scheduler.
//   start, abort       : sweep control from the consumer
//   ref_osc            : reference oscillator
//   neuron_osc         : one oscillator output per neuron
//   busy, done         : sweep status
//   result_valid/idx/phase/sat : one registered result per measured neuron
// master = whoever drives control and oscillators, slave = the scheduler.
// -----------------------------------------------------------------------------
interface phase_meas_scheduler_if
    import onn_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int CNT_W     = CNT_W_DEF
);
    localparam int IDX_W = idx_width(N_NEURONS);

    logic                 start;
    logic                 abort;
    logic                 ref_osc;
    logic [N_NEURONS-1:0] neuron_osc;
    logic                 busy;
    logic                 done;
    logic                 result_valid;
    logic [IDX_W-1:0]     result_idx;
    logic [CNT_W-1:0]     result_phase;
    logic                 result_sat;

    modport master (
        output start, abort, ref_osc, neuron_osc,
        input  busy, done, result_valid, result_idx, result_phase, result_sat
    );

    modport slave (
        input  start, abort, ref_osc, neuron_osc,
        output busy, done, result_valid, result_idx, result_phase, result_sat
    );

endinterface

// File: rtl/rise_edge_det.sv
// -----------------------------------------------------------------------------
// rise_edge_det
// Registers a W-bit input once and flags bits that are high now but were low
// in the previous cycle.
//   clk, rst : clock and synchronous active-high reset
//   x        : input vector
//   q        : x delayed by one cycle (registered)
//   rise     : x & ~q
// The register resets to 0, so a bit already high when reset drops is seen
// as a rise in the first cycle out of reset.
// -----------------------------------------------------------------------------
module rise_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] x,
    output logic [W-1:0] q,
    output logic [W-1:0] rise
);

    logic [W-1:0] x_q;
    logic [W-1:0] x_d;

    always_comb x_d = x;

    always_ff @(posedge clk) begin
        if (rst) x_q <= '0;
        else     x_q <= x_d;
    end

    assign q    = x_q;
    assign rise = x & ~x_q;

endmodule

// File: rtl/phase_meas_scheduler.sv
// -----------------------------------------------------------------------------
// phase_meas_scheduler
// Shares one phase counter across all ONN neurons. On start it walks the
// neurons in index order: waits for a reference rise, then counts cycles until
// the selected neuron rises (or the counter saturates), emits one result and
// moves on. After the last neuron, or on abort, it pulses done.
//   clk, rst : clock, synchronous active-high reset
//   bus      : phase_meas_scheduler_if.slave (control, oscillators, results)
// Every output is a flop loaded from the next-state decision, so result_valid
// is high exactly while the FSM sits in EMIT and done while it sits in NEXT.
// -----------------------------------------------------------------------------
module phase_meas_scheduler
    import onn_pkg::*;
#(
    parameter int N_NEURONS = N_NEURONS_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    phase_meas_scheduler_if.slave  bus
);

    localparam int               IDX_W    = idx_width(N_NEURONS);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    // ---------------------------------------------------------------- edges
    logic                 ref_q;
    logic                 ref_rise;
    logic [N_NEURONS-1:0] nrn_q;
    logic [N_NEURONS-1:0] nrn_rise;
    logic                 sel_rise;

    rise_edge_det #(.W(1)) u_ref_det (
        .clk  (clk),
        .rst  (rst),
        .x    (bus.ref_osc),
        .q    (ref_q),
        .rise (ref_rise)
    );

    rise_edge_det #(.W(N_NEURONS)) u_nrn_det (
        .clk  (clk),
        .rst  (rst),
        .x    (bus.neuron_osc),
        .q    (nrn_q),
        .rise (nrn_rise)
    );

    // Delayed copies are not needed here; only the rise flags are consumed.
    logic unused_delayed;
    assign unused_delayed = ref_q ^ (^nrn_q);

    // ---------------------------------------------------------------- state
    meas_state_t      state_q, state_d;
    logic [IDX_W-1:0] sel_q,   sel_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;

    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic             vld_q,   vld_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] phase_q, phase_d;
    logic             rsat_q,  rsat_d;

    // Sel mux onto the shared counter.
    assign sel_rise = nrn_rise[sel_q];

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        vld_d   = 1'b0;
        done_d  = 1'b0;
        busy_d  = 1'b0;
        idx_d   = idx_q;
        phase_d = phase_q;
        rsat_d  = rsat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_ARM;
                    sel_d   = '0;
                end
            end
            ST_ARM: begin
                if (bus.abort) begin
                    state_d = ST_NEXT;
                end else if (ref_rise) begin
                    sat_d = 1'b0;
                    if (sel_rise) begin
                        // Coincident edges: zero phase, skip counting.
                        cnt_d   = '0;
                        state_d = ST_EMIT;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_COUNT;
                    end
                end
            end
            ST_COUNT: begin
                // Further reference rises are deliberately ignored here.
                if (bus.abort) begin
                    state_d = ST_NEXT;
                end else if (sel_rise) begin
                    sat_d   = 1'b0;
                    state_d = ST_EMIT;
                end else if (cnt_q == CNT_MAX) begin
                    sat_d   = 1'b1;
                    state_d = ST_EMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_EMIT: begin
                // The result is already on the outputs this cycle, so an
                // abort here only cuts the sweep short afterwards.
                if (bus.abort || sel_q == LAST_IDX) begin
                    state_d = ST_NEXT;
                end else begin
                    sel_d   = sel_q + IDX_W'(1);
                    state_d = ST_ARM;
                end
            end
            ST_NEXT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the state being entered.
        busy_d = (state_d == ST_ARM) || (state_d == ST_COUNT) || (state_d == ST_EMIT);
        done_d = (state_d == ST_NEXT);
        if (state_d == ST_EMIT) begin
            vld_d   = 1'b1;
            idx_d   = sel_d;
            phase_d = cnt_d;
            rsat_d  = sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            vld_q   <= 1'b0;
            idx_q   <= '0;
            phase_q <= '0;
            rsat_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            vld_q   <= vld_d;
            idx_q   <= idx_d;
            phase_q <= phase_d;
            rsat_q  <= rsat_d;
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result_valid = vld_q;
    assign bus.result_idx   = idx_q;
    assign bus.result_phase = phase_q;
    assign bus.result_sat   = rsat_q;

endmodule

// File: tb/tb_phase_meas_scheduler.sv
module tb_phase_meas_scheduler;

    localparam int N   = 8;
    localparam int CW  = 4;
    localparam int MAX = (1 << CW) - 1;
    localparam int L   = 320;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    phase_meas_scheduler_if #(.N_NEURONS(N), .CNT_W(CW)) bus ();

    phase_meas_scheduler #(.N_NEURONS(N), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // wt: ARM cycles without a reference rise first; d: neuron rise offset
    // after the reference rise (-1 = never); ph/sat: expected result.
    typedef struct {
        int wt;
        int d;
        int ph;
        bit sat;
    } vec_t;
    vec_t tbl[16];

    // Random-sweep waveforms and expected results.
    logic         w_ref [L];
    logic [N-1:0] w_n   [L];
    bit           ev    [L];
    int           eidx  [L];
    int           eph   [L];
    bit           esat  [L];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_busy"},  bus.busy, 0);
        chk({nm, "_done"},  bus.done, 0);
        chk({nm, "_valid"}, bus.result_valid, 0);
        chk({nm, "_idx"},   bus.result_idx, 0);
        chk({nm, "_phase"}, bus.result_phase, 0);
        chk({nm, "_sat"},   bus.result_sat, 0);
    endtask

    // Entered with the DUT in ARM for neuron idx; returns in its EMIT cycle.
    task automatic meas(input int idx, input vec_t v);
        for (int j = 0; j < v.wt; j++) begin
            bus.ref_osc    = 1'b0;
            bus.neuron_osc = '0;
            if (j == 0 && v.wt > 1) bus.neuron_osc[idx] = 1'b1; // stray rise before ref
            tick();
            chk("arm_busy", bus.busy, 1);
            chk("arm_valid", bus.result_valid, 0);
        end
        bus.neuron_osc = '0;
        bus.ref_osc    = 1'b1;
        if (v.d == 0) bus.neuron_osc[idx] = 1'b1;
        for (int k = 1; k <= v.ph + 1; k++) begin
            tick();
            bus.ref_osc    = (k == 2 && k < v.ph); // extra ref rise while counting
            bus.neuron_osc = '0;
            if (k == v.d) bus.neuron_osc[idx] = 1'b1;
            chk("meas_busy", bus.busy, 1);
            if (k < v.ph + 1) begin
                chk("early_valid", bus.result_valid, 0);
            end else begin
                chk("valid", bus.result_valid, 1);
                chk("idx", bus.result_idx, idx);
                chk("phase", bus.result_phase, v.ph);
                chk("sat", bus.result_sat, v.sat);
            end
        end
    endtask

    task automatic start_sweep();
        bus.start      = 1'b1;
        bus.ref_osc    = 1'b0;
        bus.neuron_osc = '0;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
        chk("done_after_start", bus.done, 0);
    endtask

    task automatic table_sweep(input int base);
        start_sweep();
        for (int i = 0; i < N; i++) begin
            meas(i, tbl[base + i]);
            tick();
        end
        chk("sweep_done", bus.done, 1);
        chk("sweep_busy_low", bus.busy, 0);
        chk("sweep_no_valid", bus.result_valid, 0);
        bus.neuron_osc = '0;
        bus.ref_osc    = 1'b0;
        tick();
        chk("sweep_done_pulse", bus.done, 0);
        chk("sweep_idle_busy", bus.busy, 0);
    endtask

    function automatic bit rr(input int c);
        return (c > 0) && w_ref[c] && !w_ref[c-1];
    endfunction

    function automatic bit nr(input int i, input int c);
        return (c > 0) && w_n[c][i] && !w_n[c-1][i];
    endfunction

    task automatic rand_sweep();
        int  pick[4] = '{2, 8, 25, 50};
        int  dens[N];
        bit  lvl;
        int  c, h, arm, r, k, v, done_c, h_idx, h_ph;
        bit  hold_ok;
        for (int i = 0; i < N; i++) dens[i] = pick[$urandom_range(0, 3)];
        w_ref[0] = 1'b0;
        w_n[0]   = '0;
        lvl = 1'b0;
        c   = 1;
        while (c < L) begin
            h   = $urandom_range(1, 4);
            lvl = ~lvl;
            for (int j = 0; j < h && c < L; j++) begin
                w_ref[c] = lvl;
                c++;
            end
        end
        for (int cc = 1; cc < L; cc++)
            for (int i = 0; i < N; i++)
                w_n[cc][i] = ($urandom_range(0, 99) < dens[i]);
        for (int cc = 0; cc < L; cc++) ev[cc] = 1'b0;

        // Reference: walk the waveform neuron by neuron.
        arm = 1;
        for (int s = 0; s < N; s++) begin
            r = arm;
            while (!rr(r) && r < L - MAX - 4) r++;
            k = -1;
            for (int j = 0; j <= MAX; j++)
                if (k < 0 && nr(s, r + j)) k = j;
            v = (k < 0) ? r + MAX + 1 : r + k + 1;
            ev[v]   = 1'b1;
            eidx[v] = s;
            eph[v]  = (k < 0) ? MAX : k;
            esat[v] = (k < 0);
            arm = v + 1;
        end
        done_c = arm;

        bus.start      = 1'b1;
        bus.ref_osc    = 1'b0;
        bus.neuron_osc = '0;
        hold_ok = 1'b0;
        h_idx   = 0;
        h_ph    = 0;
        for (int c2 = 1; c2 <= done_c + 1; c2++) begin
            tick();
            bus.start      = (c2 <= done_c) && ($urandom_range(0, 9) == 0);
            bus.ref_osc    = w_ref[c2];
            bus.neuron_osc = w_n[c2];
            chk("r_valid", bus.result_valid, ev[c2]);
            chk("r_done", bus.done, (c2 == done_c));
            chk("r_busy", bus.busy, (c2 < done_c));
            if (ev[c2]) begin
                hold_ok = 1'b1;
                h_idx   = eidx[c2];
                h_ph    = eph[c2];
                chk("r_sat", bus.result_sat, esat[c2]);
            end
            if (hold_ok) begin
                chk("r_idx", bus.result_idx, h_idx);
                chk("r_phase", bus.result_phase, h_ph);
            end
        end
        bus.start      = 1'b0;
        bus.ref_osc    = 1'b0;
        bus.neuron_osc = '0;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Sweep A: corner cases; sweep B: phases 1..8.
        tbl[0] = '{0,  5,  5, 1'b0};
        tbl[1] = '{0,  0,  0, 1'b0};
        tbl[2] = '{0, -1, 15, 1'b1};
        tbl[3] = '{2,  3,  3, 1'b0};
        tbl[4] = '{0, 15, 15, 1'b0};
        tbl[5] = '{0, 16, 15, 1'b1};
        tbl[6] = '{3,  1,  1, 1'b0};
        tbl[7] = '{0,  0,  0, 1'b0};
        for (int i = 0; i < N; i++) tbl[8 + i] = '{0, i + 1, i + 1, 1'b0};

        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.ref_osc    = 1'b0;
        bus.neuron_osc = '0;
        tick(); tick(); tick();
        chk_all_zero("reset");
        rst = 1'b0;
        tick();
        chk("idle_busy", bus.busy, 0);

        table_sweep(0);
        table_sweep(8);

        // Abort in IDLE is ignored.
        bus.abort = 1'b1;
        tick(); tick();
        chk("abort_idle_busy", bus.busy, 0);
        chk("abort_idle_done", bus.done, 0);
        bus.abort = 1'b0;

        // Abort during COUNT of idx 3, with a stray start mid-sweep.
        start_sweep();
        meas(0, '{0, 2, 2, 1'b0}); tick();
        bus.start = 1'b1; bus.ref_osc = 1'b0; bus.neuron_osc = '0;
        tick();
        bus.start = 1'b0;
        chk("start_ignored_busy", bus.busy, 1);
        meas(1, '{0, 4, 4, 1'b0}); tick();
        meas(2, '{0, 1, 1, 1'b0}); tick();
        bus.ref_osc = 1'b1; bus.neuron_osc = '0;
        tick();
        bus.ref_osc = 1'b0;
        chk("cnt3_no_valid", bus.result_valid, 0);
        tick();
        bus.abort = 1'b1; bus.start = 1'b1; bus.neuron_osc[3] = 1'b1;
        tick();
        bus.abort = 1'b0; bus.start = 1'b0; bus.neuron_osc = '0;
        chk("abort_cnt_done", bus.done, 1);
        chk("abort_cnt_valid", bus.result_valid, 0);
        chk("abort_cnt_busy", bus.busy, 0);
        tick();
        chk("abort_cnt_done_pulse", bus.done, 0);
        chk("abort_cnt_idle_valid", bus.result_valid, 0);
        tick();
        chk("abort_cnt_no_queue", bus.busy, 0);

        // Abort in ARM.
        start_sweep();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_arm_done", bus.done, 1);
        chk("abort_arm_busy", bus.busy, 0);
        tick();
        chk("abort_arm_done_pulse", bus.done, 0);

        // Abort in EMIT: result already out, sweep ends next cycle.
        start_sweep();
        meas(0, '{0, 3, 3, 1'b0});
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort_emit_done", bus.done, 1);
        chk("abort_emit_valid", bus.result_valid, 0);
        chk("abort_emit_hold_phase", bus.result_phase, 3);
        tick();

        // Reset in COUNT of idx 2: everything clears, no done.
        start_sweep();
        meas(0, '{0, 5, 5, 1'b0}); tick();
        meas(1, '{0, 4, 4, 1'b0}); tick();
        bus.ref_osc = 1'b1; bus.neuron_osc = '0;
        tick();
        bus.ref_osc = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk_all_zero("mid_reset");
        rst = 1'b0;
        tick();
        chk("post_reset_done", bus.done, 0);
        chk("post_reset_busy", bus.busy, 0);
        tick();
        chk("post_reset_done2", bus.done, 0);
        start_sweep();
        meas(0, '{0, 6, 6, 1'b0});
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("restart_done", bus.done, 1);
        tick();

        for (int s = 0; s < 20; s++) rand_sweep();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
